// File: rtl/tsc_capture_sequencer.sv
// Capture sequencer for the TriggerSurroundCache: arms the TSC, drains SAMPLES samples per capture
// through a one-entry buffer, and repeats num_cap times. Optional WAIT_TRIG timeout: TSC_SEQ_TIMEOUT_EN.
module tsc_capture_sequencer #(
    parameter int unsigned SAMPLES = 16
`ifdef TSC_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic        abort,
    input  logic [7:0]  num_cap,
    output logic        start,
    output logic        req,
    output logic        sbf,
    input  logic        trd,
    input  logic        cd,
    input  logic        rdy,
    input  logic [7:0]  dat,
    input  logic [31:0] trigtm,
    input  logic        sd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic [31:0] trig_time,
    output logic        trig_valid,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        WAIT_TRIG  = 3'd2,
        WAIT_CACHE = 3'd3,
        READ       = 3'd4,
        WAIT_SD    = 3'd5,
        NEXT       = 3'd6
    } state_t;

    localparam logic [7:0] SAMPLES_C = 8'(SAMPLES);
    localparam logic [7:0] LAST_C    = 8'(SAMPLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cap_left_q, cap_left_d;
    logic [7:0]  sample_cnt_q, sample_cnt_d;
    logic        sd_seen_q, sd_seen_d;
    logic        start_q, start_d;
    logic        req_q, req_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic [31:0] trig_time_q, trig_time_d;
    logic        trig_valid_q, trig_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        arm_ok_s, load_s, drain_s, tmo_hit_s;

    assign arm_ok_s = (state_q == IDLE) && arm && (num_cap != 8'd0);
    assign load_s   = (state_q == READ) && req_q && rdy;
    assign drain_s  = out_valid_q && out_ready;

`ifdef TSC_SEQ_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST_C = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit_s = (state_q == WAIT_TRIG) && !trd && (tmo_cnt_q == TMO_LAST_C);

    // WAIT_TRIG cycle counter, restarted on every START
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (abort || (state_q == START)) begin
            tmo_cnt_d = 32'd0;
        end else if (state_q == WAIT_TRIG) begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= 32'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other input
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:       state_d = arm_ok_s ? START : IDLE;
                START:      state_d = WAIT_TRIG;
                WAIT_TRIG:  state_d = trd ? WAIT_CACHE : (tmo_hit_s ? IDLE : WAIT_TRIG);
                WAIT_CACHE: state_d = cd ? READ : WAIT_CACHE;
                READ:       state_d = ((sample_cnt_q == SAMPLES_C) && !out_valid_q) ? WAIT_SD : READ;
                WAIT_SD:    state_d = (sd || sd_seen_q) ? NEXT : WAIT_SD;
                NEXT:       state_d = (cap_left_q == 8'd1) ? IDLE : START;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Output and datapath next values
    always_comb begin
        start_d      = (state_d == START);
        busy_d       = (state_d != IDLE);
        trig_valid_d = !abort && (state_q == WAIT_TRIG) && trd;
        trig_time_d  = trig_valid_d ? trigtm : trig_time_q;
        done_d       = !abort && (state_q == NEXT) && (cap_left_q == 8'd1);
        out_data_d   = load_s ? dat : out_data_q;

        if (abort) begin
            cap_left_d = 8'd0;
        end else if (arm_ok_s) begin
            cap_left_d = num_cap;
        end else if (state_q == NEXT) begin
            cap_left_d = cap_left_q - 8'd1;
        end else begin
            cap_left_d = cap_left_q;
        end

        if (abort || (state_q == START)) begin
            sample_cnt_d = 8'd0;
            sd_seen_d    = 1'b0;
        end else begin
            sample_cnt_d = load_s ? (sample_cnt_q + 8'd1) : sample_cnt_q;
            sd_seen_d    = sd_seen_q || ((state_q == READ) && sd);
        end

        // A request is held until answered; a new one waits a full cycle after the buffer drains
        if (abort) begin
            req_d = 1'b0;
        end else if (req_q) begin
            req_d = !rdy;
        end else begin
            req_d = (state_q == READ) && !out_valid_q && (sample_cnt_q < SAMPLES_C);
        end

        if (abort) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else if (load_s) begin
            out_valid_d = 1'b1;
            out_last_d  = (sample_cnt_q == LAST_C);
        end else if (drain_s) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
            out_last_d  = out_last_q;
        end

`ifdef TSC_SEQ_TIMEOUT_EN
        if (arm_ok_s) begin
            timeout_d = 1'b0;
        end else if (tmo_hit_s && !abort) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
`else
        timeout_d = 1'b0;
`endif
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_left_q   <= 8'd0;
            sample_cnt_q <= 8'd0;
            sd_seen_q    <= 1'b0;
            start_q      <= 1'b0;
            req_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'd0;
            out_last_q   <= 1'b0;
            trig_time_q  <= 32'd0;
            trig_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            cap_left_q   <= cap_left_d;
            sample_cnt_q <= sample_cnt_d;
            sd_seen_q    <= sd_seen_d;
            start_q      <= start_d;
            req_q        <= req_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            trig_time_q  <= trig_time_d;
            trig_valid_q <= trig_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign start      = start_q;
    assign req        = req_q;
    assign sbf        = out_valid_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign trig_time  = trig_time_q;
    assign trig_valid = trig_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_tsc_capture_sequencer.sv
// Directed bench for tsc_capture_sequencer: a small TSC responder, a sink monitor and
// hand-computed expectations for single/multi capture, backpressure, abort and reset.
module tb_tsc_capture_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  num_cap = 8'd0;
    logic        start, req, sbf;
    logic        trd = 1'b0;
    logic        cd = 1'b0;
    logic        rdy = 1'b0;
    logic [7:0]  dat = 8'd0;
    logic [31:0] trigtm = 32'd0;
    logic        sd = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic [31:0] trig_time;
    logic        trig_valid, busy, done, timeout;

    int n_checks = 0;
    int n_errors = 0;

    // TSC model state
    bit          trig_en = 1'b1;
    logic [7:0]  dat_next = 8'd0;
    logic        req_seen = 1'b0;
    int          tcnt = 0;
    int          cap_n = 0;
    int          sd_delay = 1;
    int          sd_cnt = 0;
    logic [31:0] trig_base = 32'h1234_5678;

    // Monitor counters
    int beats = 0;
    int lasts = 0;
    int starts = 0;
    int tvs = 0;
    int dones = 0;
    int viol = 0;

    always #5 clk = ~clk;

`ifdef TSC_SEQ_TIMEOUT_EN
    tsc_capture_sequencer #(.SAMPLES(16), .TIMEOUT_CYCLES(20)) dut (
`else
    tsc_capture_sequencer #(.SAMPLES(16)) dut (
`endif
        .clk(clk), .reset(rst_n), .arm(arm), .abort(abort), .num_cap(num_cap),
        .start(start), .req(req), .sbf(sbf), .trd(trd), .cd(cd), .rdy(rdy),
        .dat(dat), .trigtm(trigtm), .sd(sd), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .trig_time(trig_time), .trig_valid(trig_valid), .busy(busy),
        .done(done), .timeout(timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        beats = 0; lasts = 0; starts = 0; tvs = 0; dones = 0;
        dat_next = 8'd0; cap_n = 0;
    endtask

    task automatic pulse_arm(input logic [7:0] n);
        num_cap = n;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (dones == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_beats(input int n);
        int k;
        k = 0;
        while (beats < n && k < 400) begin
            @(negedge clk);
            k++;
        end
    endtask

    // TSC responder: trigger+cache-done 5 cycles after start, rdy one cycle after req, sd after last sample
    initial begin : tsc_model
        forever begin
            @(negedge clk);
            if (start) begin
                trd = 1'b0; cd = 1'b0; tcnt = 5; cap_n++;
            end else if (tcnt > 0) begin
                tcnt--;
                if (tcnt == 0 && trig_en) begin
                    trd = 1'b1; cd = 1'b1;
                    trigtm = trig_base + 32'(cap_n - 1);
                end
            end
            sd = 1'b0;
            if (sd_cnt > 0) begin
                sd_cnt--;
                if (sd_cnt == 0) sd = 1'b1;
            end
            if (req && req_seen && !rdy) begin
                rdy = 1'b1;
                dat = dat_next;
                if (dat_next[3:0] == 4'd15) sd_cnt = sd_delay;
                dat_next = dat_next + 8'd1;
            end else begin
                rdy = 1'b0;
            end
            req_seen = req;
        end
    end

    // Sink monitor: beat ordering, out_last position, pulse counts and handshake invariants
    initial begin : sink_monitor
        forever begin
            @(negedge clk);
            #1;
            if (start) starts++;
            if (trig_valid) tvs++;
            if (done) dones++;
            if ((sbf !== out_valid) || (req && out_valid)) viol++;
            if (out_valid && out_ready) begin
                check_eq("beat_data", 32'(out_data), 32'(beats & 255));
                check_eq("beat_last", 32'(out_last), 32'((beats % 16) == 15));
                if (out_last) lasts++;
                beats++;
            end
        end
    end

    initial begin : main
        // Reset state with all inputs low
        tick(3);
        check_eq("rst_ctl", {22'd0, start, req, sbf, out_valid, out_last, trig_valid, busy, done, timeout, 1'b0},
                 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_trig_time", trig_time, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(2);

        // arm with num_cap=0 is ignored
        pulse_arm(8'd0);
        check_eq("arm0_busy", 32'(busy), 32'd0);
        check_eq("arm0_start", 32'(start), 32'd0);
        tick(2);

        // Single capture, plus a stray arm during READ that must be ignored
        clear_counts();
        sd_delay = 1;
        pulse_arm(8'd1);
        check_eq("a_start", 32'(start), 32'd1);
        check_eq("a_busy", 32'(busy), 32'd1);
        wait_beats(2);
        num_cap = 8'd5; arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        wait_done(300);
        check_eq("a_busy_end", 32'(busy), 32'd0);
        tick(3);
        check_eq("a_beats", 32'(beats), 32'd16);
        check_eq("a_lasts", 32'(lasts), 32'd1);
        check_eq("a_starts", 32'(starts), 32'd1);
        check_eq("a_tvs", 32'(tvs), 32'd1);
        check_eq("a_dones", 32'(dones), 32'd1);
        check_eq("a_trig_time", trig_time, 32'h1234_5678);

        // Three captures, sd arriving only after WAIT_SD is entered
        clear_counts();
        sd_delay = 6;
        pulse_arm(8'd3);
        wait_done(800);
        tick(3);
        check_eq("b_beats", 32'(beats), 32'd48);
        check_eq("b_lasts", 32'(lasts), 32'd3);
        check_eq("b_starts", 32'(starts), 32'd3);
        check_eq("b_tvs", 32'(tvs), 32'd3);
        check_eq("b_dones", 32'(dones), 32'd1);
        check_eq("b_trig_time", trig_time, 32'h1234_567A);

        // Backpressure: out_ready low for 10 cycles after the first beat
        clear_counts();
        sd_delay = 1;
        pulse_arm(8'd1);
        wait_beats(1);
        out_ready = 1'b0;
        tick(10);
        check_eq("c_sbf", 32'(sbf), 32'd1);
        check_eq("c_req", 32'(req), 32'd0);
        check_eq("c_valid", 32'(out_valid), 32'd1);
        check_eq("c_data", 32'(out_data), 32'd1);
        check_eq("c_beats_held", 32'(beats), 32'd1);
        out_ready = 1'b1;
        wait_done(300);
        tick(2);
        check_eq("c_beats", 32'(beats), 32'd16);
        check_eq("c_dones", 32'(dones), 32'd1);

        // Abort during READ after 4 samples
        clear_counts();
        pulse_arm(8'd2);
        wait_beats(4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("d_busy", 32'(busy), 32'd0);
        check_eq("d_valid", 32'(out_valid), 32'd0);
        check_eq("d_req", 32'(req), 32'd0);
        check_eq("d_trig_kept", trig_time, 32'h1234_5678);
        tick(5);
        check_eq("d_no_done", 32'(dones), 32'd0);
        clear_counts();
        pulse_arm(8'd1);
        check_eq("d_restart", 32'(start), 32'd1);
        wait_done(300);
        tick(2);
        check_eq("d_beats", 32'(beats), 32'd16);
        check_eq("d_dones", 32'(dones), 32'd1);

`ifdef TSC_SEQ_TIMEOUT_EN
        // Timeout: trd never asserted
        begin
            int k;
            clear_counts();
            trig_en = 1'b0;
            pulse_arm(8'd1);
            k = 1;
            while (busy && k < 100) begin
                @(negedge clk);
                k++;
            end
            check_eq("f_cycles", 32'(k), 32'd22);
            check_eq("f_timeout", 32'(timeout), 32'd1);
            check_eq("f_no_done", 32'(dones), 32'd0);
            pulse_arm(8'd1);
            check_eq("f_cleared", 32'(timeout), 32'd0);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            trig_en = 1'b1;
            tick(2);
        end
`endif

        // Asynchronous reset mid-READ
        begin
            int k;
            clear_counts();
            pulse_arm(8'd1);
            k = 0;
            while (!out_valid && k < 200) begin
                @(negedge clk);
                k++;
            end
            check_eq("e_loaded", 32'(out_valid), 32'd1);
            #2;
            rst_n = 1'b0;
            #1;
            check_eq("e_req", 32'(req), 32'd0);
            check_eq("e_valid", 32'(out_valid), 32'd0);
            check_eq("e_busy", 32'(busy), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            tick(2);
            check_eq("e_idle", 32'(busy), 32'd0);
        end

        check_eq("invariants", 32'(viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
